// File: rtl/decimal_entry.sv
// Decimal digit entry: accumulates BCD digits (MSD first) into a W-bit binary operand.
// Optional build macro DECIMAL_ENTRY_SAT_EN: saturate instead of wrap on overflow.
module decimal_entry #(
  parameter  int DIGITS = 2,
  parameter  int W      = 8,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    digit,
  input  logic          digit_valid,
  output logic          digit_ready,
  input  logic          commit,
  input  logic          clear,
  output logic [W-1:0]  value,
  output logic          value_valid,
  input  logic          value_ready,
  output logic [CW-1:0] digit_count,
  output logic          overflow,
  output logic          bad_digit
);

`ifdef DECIMAL_ENTRY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ENTRY, MAC, HOLD} state_t;

  state_t        r_state, w_state_nx;
  logic [W-1:0]  r_acc, w_acc_nx;
  logic [3:0]    r_digit_p0, w_digit_nx;
  logic [W-1:0]  r_value, w_value_nx;
  logic          r_value_valid, w_vv_nx;
  logic [CW-1:0] r_count, w_count_nx;
  logic          r_overflow, w_ovf_nx;
  logic          r_bad, w_bad_nx;

  logic          w_ready;
  logic          w_xfer;
  logic [W+3:0]  w_acc_ext;
  logic [W+3:0]  w_mac;

  // Wrap keeps the low W bits; saturation clamps any out-of-range result to all ones.
  function automatic logic [W-1:0] fn_limit(input logic [W+3:0] m);
    if (SAT && (|m[W+3:W])) fn_limit = '1;
    else                     fn_limit = m[W-1:0];
  endfunction

  assign w_ready = !rst && ((r_state == IDLE) || (r_state == ENTRY)) &&
                   (r_count < CW'(DIGITS)) && !commit && !clear;
  assign w_xfer  = digit_valid && w_ready;

  // acc*10 + digit as shift-add, wide enough to see every overflow bit.
  assign w_acc_ext = {4'b0000, r_acc};
  assign w_mac     = (w_acc_ext << 3) + (w_acc_ext << 1) + {{W{1'b0}}, r_digit_p0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_digit_nx = r_digit_p0;
    w_value_nx = r_value;
    w_vv_nx    = r_value_valid;
    w_count_nx = r_count;
    w_ovf_nx   = r_overflow;
    w_bad_nx   = 1'b0;
    if (clear) begin
      w_state_nx = IDLE;
      w_acc_nx   = '0;
      w_count_nx = '0;
      w_ovf_nx   = 1'b0;
      w_vv_nx    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE, ENTRY: begin
          if (commit) begin
            w_value_nx = r_acc;
            w_vv_nx    = 1'b1;
            w_state_nx = HOLD;
          end else if (w_xfer) begin
            if (digit <= 4'd9) begin
              w_digit_nx = digit;
              w_state_nx = MAC;
            end else begin
              w_bad_nx   = 1'b1;
            end
          end
        end
        MAC: begin
          w_acc_nx   = fn_limit(w_mac);
          if (|w_mac[W+3:W]) w_ovf_nx = 1'b1;
          w_count_nx = r_count + CW'(1);
          w_state_nx = ENTRY;
        end
        HOLD: begin
          if (value_ready) begin
            w_vv_nx    = 1'b0;
            w_acc_nx   = '0;
            w_count_nx = '0;
            w_ovf_nx   = 1'b0;
            w_state_nx = IDLE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Stage boundary: digit latched in the transfer cycle, folded into acc in the MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc         <= '0;
      r_digit_p0    <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_bad         <= 1'b0;
    end else begin
      r_acc         <= w_acc_nx;
      r_digit_p0    <= w_digit_nx;
      r_value       <= w_value_nx;
      r_value_valid <= w_vv_nx;
      r_count       <= w_count_nx;
      r_overflow    <= w_ovf_nx;
      r_bad         <= w_bad_nx;
    end
  end

  assign digit_ready = w_ready;
  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign digit_count = r_count;
  assign overflow    = r_overflow;
  assign bad_digit   = r_bad;

endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry: scoreboard of committed values, immediate-assertion checks.
module tb_decimal_entry;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit;
  logic       digit_valid, digit_ready, commit, clear, value_ready;
  logic [7:0] value;
  logic       value_valid, overflow, bad_digit;
  logic [1:0] digit_count;

  logic [3:0] d3_digit;
  logic       d3_digit_valid, d3_digit_ready, d3_commit, d3_clear, d3_value_ready;
  logic [7:0] d3_value;
  logic       d3_value_valid, d3_overflow, d3_bad_digit;
  logic [1:0] d3_digit_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  decimal_entry #(.DIGITS(2), .W(8)) u_dut (
    .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .commit(commit), .clear(clear), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .digit_count(digit_count), .overflow(overflow),
    .bad_digit(bad_digit));

  decimal_entry #(.DIGITS(3), .W(8)) u_dut3 (
    .clk(clk), .rst(rst), .digit(d3_digit), .digit_valid(d3_digit_valid),
    .digit_ready(d3_digit_ready), .commit(d3_commit), .clear(d3_clear), .value(d3_value),
    .value_valid(d3_value_valid), .value_ready(d3_value_ready), .digit_count(d3_digit_count),
    .overflow(d3_overflow), .bad_digit(d3_bad_digit));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_digit(input logic [3:0] d);
    int n;
    @(negedge clk);
    digit = d;
    digit_valid = 1'b1;
    #1;
    n = 0;
    while (!digit_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("send_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic send3(input logic [3:0] d);
    int n;
    @(negedge clk);
    d3_digit = d;
    d3_digit_valid = 1'b1;
    #1;
    n = 0;
    while (!d3_digit_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("send3_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    d3_digit_valid = 1'b0;
  endtask

  task automatic do_commit(input int v);
    @(negedge clk);
    commit = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic expect_value(input string tag);
    int n;
    int ex;
    n = 0;
    while (!value_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vv"}, 32'(value_valid), 32'd1);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk(tag, 32'(value), 32'(ex));
    @(negedge clk);
    chk({tag, "_hold_vv"}, 32'(value_valid), 32'd1);
    chk({tag, "_hold"}, 32'(value), 32'(ex));
    value_ready = 1'b1;
    @(negedge clk);
    value_ready = 1'b0;
    chk({tag, "_vv_low"}, 32'(value_valid), 32'd0);
    chk({tag, "_cnt0"}, 32'(digit_count), 32'd0);
    chk({tag, "_keep"}, 32'(value), 32'(ex));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex;
    rst = 1'b1;
    digit = '0; digit_valid = 1'b0; commit = 1'b0; clear = 1'b0; value_ready = 1'b0;
    d3_digit = '0; d3_digit_valid = 1'b0; d3_commit = 1'b0; d3_clear = 1'b0;
    d3_value_ready = 1'b0;
    #2;
    digit_valid = 1'b1;
    #1;
    chk("rst_ready", 32'(digit_ready), 32'd0);
    chk("rst_vv", 32'(value_valid), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_cnt", 32'(digit_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_bad", 32'(bad_digit), 32'd0);
    digit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 4,2 then commit -> 42
    send_digit(4'd4);
    chk("mac_ready_low", 32'(digit_ready), 32'd0);
    send_digit(4'd2);
    @(negedge clk);
    chk("t1_cnt", 32'(digit_count), 32'd2);
    do_commit(42);
    expect_value("t1_value");

    // 7, illegal 0xB, commit -> 7
    send_digit(4'd7);
    send_digit(4'hB);
    chk("t2_bad_pulse", 32'(bad_digit), 32'd1);
    chk("t2_cnt", 32'(digit_count), 32'd1);
    @(negedge clk);
    chk("t2_bad_end", 32'(bad_digit), 32'd0);
    chk("t2_cnt_keep", 32'(digit_count), 32'd1);
    do_commit(7);
    expect_value("t2_value");

    // full entry back-pressures a third digit
    send_digit(4'd1);
    send_digit(4'd2);
    @(negedge clk);
    digit = 4'd3;
    digit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready_low", 32'(digit_ready), 32'd0);
      @(negedge clk);
    end
    chk("t3_cnt", 32'(digit_count), 32'd2);
    digit_valid = 1'b0;
    do_commit(12);
    expect_value("t3_value");

    // clear during the MAC cycle
    send_digit(4'd5);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_cnt", 32'(digit_count), 32'd0);
    chk("t5_vv", 32'(value_valid), 32'd0);
    do_commit(0);
    expect_value("t5_value");

    // async reset while holding a published value
    send_digit(4'd3);
    do_commit(3);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk("t5_hold_vv", 32'(value_valid), 32'd1);
    chk("t5_hold_val", 32'(value), 32'(ex));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_vv", 32'(value_valid), 32'd0);
    chk("t5_rst_val", 32'(value), 32'd0);
    chk("t5_rst_cnt", 32'(digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // commit and digit in the same IDLE cycle
    @(negedge clk);
    digit = 4'd9;
    digit_valid = 1'b1;
    commit = 1'b1;
    exp_q.push_back(0);
    #1;
    chk("t6_ready_low", 32'(digit_ready), 32'd0);
    @(negedge clk);
    commit = 1'b0;
    chk("t6_cnt", 32'(digit_count), 32'd0);
    expect_value("t6_value");
    @(negedge clk);
    digit_valid = 1'b0;
    @(negedge clk);
    chk("t6_pending_taken", 32'(digit_count), 32'd1);
    do_commit(9);
    expect_value("t6_value9");

    // 3-digit instance overflows on 300
    send3(4'd3);
    send3(4'd0);
    @(negedge clk);
    chk("t4_no_ovf", 32'(d3_overflow), 32'd0);
    send3(4'd0);
    @(negedge clk);
    chk("t4_ovf", 32'(d3_overflow), 32'd1);
    chk("t4_cnt", 32'(d3_digit_count), 32'd3);
    d3_commit = 1'b1;
    @(negedge clk);
    d3_commit = 1'b0;
    chk("t4_vv", 32'(d3_value_valid), 32'd1);
`ifdef DECIMAL_ENTRY_SAT_EN
    chk("t4_value", 32'(d3_value), 32'd255);
`else
    chk("t4_value", 32'(d3_value), 32'd44);
`endif
    d3_value_ready = 1'b1;
    @(negedge clk);
    d3_value_ready = 1'b0;
    chk("t4_ovf_clr", 32'(d3_overflow), 32'd0);
    chk("t4_vv_low", 32'(d3_value_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
